// File: rtl/button_event_classifier.sv
// button_event_classifier
// Turns one-cycle press/release pulses from the debounced edge detector into
// short press, long press and double click pulses plus a held-level flag.
// A private millisecond timebase restarts on every state change, so every
// timeout counts from the cycle that caused entry into the current state.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (auto-repeat pulses while a
// long press is held). With the macro undefined, repeat_pulse is constant 0.
module button_event_classifier #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int LONG_MS     = 1000,
    parameter int DCLICK_MS   = 300,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic i_rise,
    input  logic i_fall,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic pressed
);

    localparam int DIV   = CLK_FREQ_HZ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(DIV - 1);
    localparam logic [15:0]      LONG_LAST   = 16'(LONG_MS - 1);
    localparam logic [15:0]      DCLICK_LAST = 16'(DCLICK_MS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_WAIT2  = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [2:0] S_LONG   = 3'd4;

    // Parameter sanity checks at elaboration time
    if ((CLK_FREQ_HZ < 1000) || ((CLK_FREQ_HZ % 1000) != 0)) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a multiple of 1000 and at least 1000");
    end
    if ((LONG_MS < 1) || (LONG_MS > 65535)) begin : g_bad_long
        $error("LONG_MS must be in 1..65535");
    end
    if ((DCLICK_MS < 1) || (DCLICK_MS > 65535)) begin : g_bad_dclick
        $error("DCLICK_MS must be in 1..65535");
    end
    if ((REPEAT_MS < 1) || (REPEAT_MS > 65535)) begin : g_bad_repeat
        $error("REPEAT_MS must be in 1..65535");
    end

    // Millisecond counter saturates instead of wrapping back to zero
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [PRE_W-1:0] r_pre;
    logic [15:0]      r_ms;

    logic w_rise;
    logic w_fall;
    logic w_tick;
    logic w_exp_long;
    logic w_exp_dclick;
    logic w_exp_rep;
    logic w_clear;

    logic w_short_nx;
    logic w_long_nx;
    logic w_dbl_nx;
    logic w_rep_nx;
    logic w_pressed_nx;

    logic r_short;
    logic r_long;
    logic r_dbl;
    logic r_pressed;

    // Simultaneous press and release pulses cancel out
    assign w_rise = i_rise & ~i_fall;
    assign w_fall = i_fall & ~i_rise;

    // A timeout of N ms expires on the tick that would take ms_cnt to N
    assign w_tick       = (r_pre == PRE_LAST);
    assign w_exp_long   = w_tick && (r_ms == LONG_LAST);
    assign w_exp_dclick = w_tick && (r_ms == DCLICK_LAST);

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_MS - 1);
    assign w_exp_rep = w_tick && (r_ms == REPEAT_LAST);
`else
    assign w_exp_rep = 1'b0;
`endif

    // Timer restarts on any state change and after each repeat pulse
    assign w_clear = (w_next_state != r_state) || w_rep_nx;

    // Prescaler and millisecond counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (w_clear) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_ms <= sat_inc(r_ms);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a release or press on an expiry cycle beats the timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_next_state = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_fall)          w_next_state = S_WAIT2;
                else if (w_exp_long) w_next_state = S_LONG;
            end
            S_WAIT2: begin
                if (w_rise)            w_next_state = S_PRESS2;
                else if (w_exp_dclick) w_next_state = S_IDLE;
            end
            S_PRESS2: begin
                if (w_fall) w_next_state = S_IDLE;
            end
            S_LONG: begin
                if (w_fall) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: values to be registered on the coming edge
    always_comb begin
        w_short_nx   = (r_state == S_WAIT2)  && !w_rise && w_exp_dclick;
        w_long_nx    = (r_state == S_PRESS1) && !w_fall && w_exp_long;
        w_dbl_nx     = (r_state == S_PRESS2) && w_fall;
        w_rep_nx     = (r_state == S_LONG)   && !w_fall && w_exp_rep;
        w_pressed_nx = (w_next_state == S_PRESS1) ||
                       (w_next_state == S_PRESS2) ||
                       (w_next_state == S_LONG);
    end

    // Registered event pulses and held flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_dbl     <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_short   <= w_short_nx;
            r_long    <= w_long_nx;
            r_dbl     <= w_dbl_nx;
            r_pressed <= w_pressed_nx;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    logic r_repeat;

    // Auto-repeat pulse register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_rep_nx;
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_dbl;
    assign pressed      = r_pressed;

endmodule

// File: tb/tb_button_event_classifier.sv
// Testbench for button_event_classifier (DIV=10, LONG_MS=20, DCLICK_MS=5,
// REPEAT_MS=3). Expected outputs come from a deadline-based reference model
// working in absolute cycle numbers. Honours BUTTON_AUTO_REPEAT_EN.
module tb_button_event_classifier;

    localparam int CLK_HZ  = 10_000;
    localparam int DIV     = CLK_HZ / 1000;
    localparam int L_MS    = 20;
    localparam int D_MS    = 5;
    localparam int R_MS    = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic i_rise = 1'b0;
    logic i_fall = 1'b0;
    logic short_press, long_press, double_click, repeat_pulse, pressed;
    logic [4:0] w_obs;

    int n_cmp = 0;
    int n_fail = 0;
    int g_cyc = 0;

    // model: 0 idle, 1 first hold, 2 release gap, 3 second hold, 4 long hold
    int m_phase = 0;
    int m_deadline = 0;
    int m_rep_deadline = 0;
    logic [4:0] e_vec = 5'b0;

    button_event_classifier #(
        .CLK_FREQ_HZ(CLK_HZ),
        .LONG_MS(L_MS),
        .DCLICK_MS(D_MS),
        .REPEAT_MS(R_MS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_rise(i_rise),
        .i_fall(i_fall),
        .short_press(short_press),
        .long_press(long_press),
        .double_click(double_click),
        .repeat_pulse(repeat_pulse),
        .pressed(pressed)
    );

    assign w_obs = {short_press, long_press, double_click, repeat_pulse, pressed};

    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic f, input logic rst_n);
        logic rise, fall;
        logic es, el, ed, er;
        rise = r & ~f;
        fall = f & ~r;
        es = 1'b0; el = 1'b0; ed = 1'b0; er = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (rise) begin
                    m_phase = 1;
                    m_deadline = g_cyc + L_MS * DIV;
                end
                1: if (fall) begin
                    m_phase = 2;
                    m_deadline = g_cyc + D_MS * DIV;
                end else if (g_cyc == m_deadline) begin
                    m_phase = 4;
                    el = 1'b1;
                    m_rep_deadline = g_cyc + R_MS * DIV;
                end
                2: if (rise) begin
                    m_phase = 3;
                end else if (g_cyc == m_deadline) begin
                    m_phase = 0;
                    es = 1'b1;
                end
                3: if (fall) begin
                    m_phase = 0;
                    ed = 1'b1;
                end
                default: if (fall) begin
                    m_phase = 0;
                end else if (g_cyc == m_rep_deadline) begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    er = 1'b1;
`endif
                    m_rep_deadline = g_cyc + R_MS * DIV;
                end
            endcase
        end
        e_vec = {es, el, ed, er, (m_phase == 1 || m_phase == 3 || m_phase == 4)};
    endtask

    // Drive one cycle of inputs; afterwards outputs of the next cycle are visible
    task automatic step(input logic r, input logic f);
        i_rise = r;
        i_fall = f;
        @(posedge clk);
        model_update(r, f, reset);
        #1;
        g_cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 1'b0);
        n_cmp++;
        if (w_obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=00000", w_obs);
        end
        step(1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        n_cmp++;
        if (w_obs !== 5'b0 || e_vec !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle got=%b exp=00000", w_obs);
        end
    endtask

    task automatic test_short();
        int ns, ts, nother, p_on, p_off;
        ns = 0; ts = -1; nother = 0; p_on = -1; p_off = -1;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step(c == 0, c == 50);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL short_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if (short_press) begin ns++; ts = c + 1; end
            if (long_press || double_click || repeat_pulse) nother++;
            if (pressed && p_on < 0) p_on = c + 1;
            if (!pressed && p_on >= 0 && p_off < 0) p_off = c + 1;
        end
        n_cmp++;
        if (ns !== 1 || ts !== 101) begin
            n_fail++;
            $display("FAIL short_pulse count=%0d at=%0d exp count=1 at=101", ns, ts);
        end
        n_cmp++;
        if (p_on !== 1 || p_off !== 51 || nother !== 0) begin
            n_fail++;
            $display("FAIL short_pressed on=%0d off=%0d other=%0d exp 1 51 0", p_on, p_off, nother);
        end
    endtask

    task automatic test_long_repeat();
        int nl, tl, ns, nr, p_off;
        int tr[$];
        nl = 0; tl = -1; ns = 0; nr = 0; p_off = -1;
        do_reset();
        for (int c = 0; c < 450; c++) begin
            step(c == 0, c == 300);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if (long_press) begin nl++; tl = c + 1; end
            if (short_press) ns++;
            if (repeat_pulse) begin nr++; tr.push_back(c + 1); end
            if (!pressed && c > 0 && p_off < 0) p_off = c + 1;
        end
        n_cmp++;
        if (nl !== 1 || tl !== 201 || ns !== 0 || p_off !== 301) begin
            n_fail++;
            $display("FAIL long_pulse n=%0d at=%0d short=%0d off=%0d exp 1 201 0 301", nl, tl, ns, p_off);
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        n_cmp++;
        if (nr !== 3 || tr.size() != 3 || tr[0] !== 231 || tr[1] !== 261 || tr[2] !== 291) begin
            n_fail++;
            $display("FAIL repeat_times n=%0d exp 3 pulses at 231 261 291", nr);
        end
`else
        n_cmp++;
        if (nr !== 0) begin
            n_fail++;
            $display("FAIL repeat_off n=%0d exp=0", nr);
        end
`endif
    endtask

    task automatic test_double();
        int nd, td, ns;
        nd = 0; td = -1; ns = 0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step(c == 0 || c == 60, c == 30 || c == 90);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL double_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if (double_click) begin nd++; td = c + 1; end
            if (short_press) ns++;
        end
        n_cmp++;
        if (nd !== 1 || td !== 91 || ns !== 0) begin
            n_fail++;
            $display("FAIL double_pulse n=%0d at=%0d short=%0d exp 1 91 0", nd, td, ns);
        end
    endtask

    task automatic test_boundary();
        int nl, ns, ts, nd, td;
        nl = 0; ns = 0; ts = -1;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step(c == 0, c == 200);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL blong_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if (long_press) nl++;
            if (short_press) begin ns++; ts = c + 1; end
        end
        n_cmp++;
        if (nl !== 0 || ns !== 1 || ts !== 251) begin
            n_fail++;
            $display("FAIL boundary_long long=%0d short=%0d at=%0d exp 0 1 251", nl, ns, ts);
        end
        nd = 0; td = -1; ns = 0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            step(c == 0 || c == 80, c == 30 || c == 100);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL bdclick_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if (double_click) begin nd++; td = c + 1; end
            if (short_press) ns++;
        end
        n_cmp++;
        if (nd !== 1 || td !== 101 || ns !== 0) begin
            n_fail++;
            $display("FAIL boundary_dclick n=%0d at=%0d short=%0d exp 1 101 0", nd, td, ns);
        end
    endtask

    task automatic test_reset_mid();
        int nl, tl, nz;
        nl = 0; tl = -1; nz = 0;
        do_reset();
        for (int c = 0; c < 650; c++) begin
            reset = !(c == 150 || c == 151);
            step(c == 0 || c == 400, 1'b0);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
            if ((c == 150 || c == 151) && w_obs !== 5'b0) nz++;
            if (long_press) begin nl++; tl = c + 1; end
        end
        reset = 1'b1;
        n_cmp++;
        if (nz !== 0 || nl !== 1 || tl !== 601) begin
            n_fail++;
            $display("FAIL reset_mid nonzero=%0d long=%0d at=%0d exp 0 1 601", nz, nl, tl);
        end
    endtask

    task automatic test_random();
        int rr, thr;
        logic r, f;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            thr = (c < 2000) ? 20 : 3;
            rr = $urandom_range(0, 999);
            r = (rr < thr) || (rr >= 990 && rr < 993);
            f = (rr >= thr && rr < 2 * thr) || (rr >= 990 && rr < 993);
            reset = (rr != 999);
            step(r, f);
            n_cmp++;
            if (w_obs !== e_vec) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", c + 1, w_obs, e_vec);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        #2;
        test_reset();
        test_short();
        test_long_repeat();
        test_double();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Downstream consumer of the debounced button edge detector's one-cycle rising_edge/falling_edge pulses.
- Classifies press activity into short press, long press and double click, each reported as a one-cycle pulse, plus a held-level flag.
- Sits between the button front end and control FSMs such as mode select and counter run/stop.
- Contains its own millisecond timebase derived from clk.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clk frequency; must be a multiple of 1000 and >= 1000; DIV = CLK_FREQ_HZ/1000 clocks per ms.
- LONG_MS, 1000, hold time (ms) that qualifies a long press; range 1..65535.
- DCLICK_MS, 300, maximum release gap (ms) that still allows a double click; range 1..65535.
- REPEAT_MS, 200, auto-repeat period (ms); used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset; sampled on posedge clk, active when 0
- i_rise  input  1  press event, one-cycle pulse (rising_edge of the detector)
- i_fall  input  1  release event, one-cycle pulse (falling_edge of the detector)
- short_press  output  1  one-cycle pulse: single press, released before LONG_MS, no second press within DCLICK_MS
- long_press  output  1  one-cycle pulse: press held for LONG_MS
- double_click  output  1  one-cycle pulse: release of the second press
- repeat_pulse  output  1  one-cycle auto-repeat pulse while a long press is held (see Optional Feature)
- pressed  output  1  level; 1 in PRESS1, PRESS2, LONG_HOLD

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, prescaler=0, ms_cnt=0, all outputs 0. Reset mid-sequence aborts it and emits no pulse.
- Timebase: prescaler counts 0..DIV-1 and produces ms_tick on DIV-1. ms_cnt is 16 bit, increments on ms_tick and saturates at 0xFFFF.
- On every state transition, prescaler and ms_cnt clear to 0. Elapsed time in a state is therefore exact: timeout N fires exactly N*DIV cycles after the entry-causing sample cycle.
- Outputs are registered. A pulse is high for exactly 1 cycle, the cycle after the posedge that evaluates the causing event. At most one of short_press/long_press/double_click is high per cycle.
- Input i_rise and i_fall both 1 in the same cycle: treated as no event.
- States and transitions:
  - IDLE: i_rise -> PRESS1. i_fall ignored.
  - PRESS1:
    - i_fall -> WAIT2.
    - ms_cnt reaches LONG_MS -> LONG_HOLD, pulse long_press.
    - i_fall on the expiry cycle wins: -> WAIT2, no long_press.
  - WAIT2:
    - i_rise -> PRESS2.
    - ms_cnt reaches DCLICK_MS -> IDLE, pulse short_press.
    - i_rise on the expiry cycle wins: -> PRESS2, no short_press.
  - PRESS2: i_fall -> IDLE, pulse double_click, regardless of hold duration. No timeout in this state.
  - LONG_HOLD: i_fall -> IDLE, no further pulse. Stray i_rise is ignored.
- Stray i_rise in PRESS1/PRESS2 and stray i_fall in WAIT2 are ignored and do not reset the timer.
- State encoding: 3 bits, one-hot or binary at implementer's choice. Unused codes recover to IDLE on the next clock.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In LONG_HOLD, repeat_pulse fires every REPEAT_MS ms. The first pulse comes REPEAT_MS*DIV cycles after the long_press pulse, with the timer restarting after each pulse.
  - Stops immediately on i_fall or reset.
- Not defined: repeat_pulse is tied to 0, repeat logic is not synthesized, and REPEAT_MS is unused.

Test Plan (CLK_FREQ_HZ=10_000 so DIV=10; LONG_MS=20, DCLICK_MS=5, REPEAT_MS=3):
- Rise at cycle 0, fall at cycle 50 -> pressed high from cycle 1 to 51; short_press single pulse at cycle 101 (fall + 50 + 1); no other pulses.
- Rise at 0, held -> long_press pulse at cycle 201, pressed stays 1. Fall at 400 -> pressed 0 at 401, no short_press.
- Rise 0, fall 30, rise 60, fall 90 -> exactly one double_click at cycle 91; no short_press in the following 200 cycles.
- Boundary cases:
  - Rise 0, fall exactly at cycle 200 -> no long_press; short_press at cycle 251.
  - Separately, fall 30, rise exactly at 80 -> PRESS2; fall at 100 -> double_click at 101.
- Reset held low at cycle 150 during PRESS1 for 2 cycles -> all outputs 0, no long_press ever. A subsequent rise restarts the full 200-cycle timing.
- With BUTTON_AUTO_REPEAT_EN: rise 0, fall 300 -> long_press at 201, repeat_pulse at 231, 261, 291, none afterwards. Without the macro, repeat_pulse stays 0 throughout.
